// File: rtl/nonce_dispatcher_pkg.sv
// Shared definitions for the nonce dispatcher: nonce geometry inside the blob
// and the controller state encoding.
package nonce_dispatcher_pkg;

    localparam int NONCE_BITS        = 32;
    localparam int NONCE_BYTE_OFFSET = 39;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte 0 sits at the MSB end of the blob.
    function automatic int byte_lsb(input int width, input int k);
        return width - 8 - 8 * k;
    endfunction

endpackage

// File: rtl/nonce_dispatcher_splice.sv
// Combinational nonce insertion: the 32-bit nonce is written little-endian into
// blob bytes 39..42; every other byte passes through.
module nonce_splice
    import nonce_dispatcher_pkg::*;
#(
    parameter int input_width = 2144
) (
    input  logic [input_width-1:0] i_blob,
    input  logic [NONCE_BITS-1:0]  i_nonce,
    output logic [input_width-1:0] o_blob
);

    always_comb begin
        o_blob = i_blob;
        for (int i = 0; i < NONCE_BITS / 8; i++) begin
            o_blob[byte_lsb(input_width, NONCE_BYTE_OFFSET + i) +: 8] = i_nonce[8*i +: 8];
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Job-level nonce sequencer: latches one mining job and streams one spliced
// blob per nonce over a valid/ready handshake, with abort and a done pulse.
module nonce_dispatcher
    import nonce_dispatcher_pkg::*;
#(
    parameter int nonce_width = 7,
    parameter int input_width = 2144,
    parameter int cnt_width   = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_job_valid,
    output logic                   o_job_ready,
    input  logic [input_width-1:0] i_job_blob,
    input  logic [NONCE_BITS-1:0]  i_job_start_nonce,
    input  logic [cnt_width-1:0]   i_job_count,
    input  logic                   i_abort,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [nonce_width-1:0] o_nonce,
    output logic [input_width-1:0] o_data,
    output logic                   o_busy,
    output logic                   o_job_done,
    output logic [cnt_width-1:0]   o_sent
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [input_width-1:0] r_blob;
    logic [NONCE_BITS-1:0]  r_nonce;
    logic [cnt_width-1:0]   r_rem;
    logic [cnt_width-1:0]   r_sent;
    logic                   w_accept;
    logic                   w_handshake;

    assign w_accept    = (r_state == ST_IDLE) && i_job_valid;
    assign w_handshake = (r_state == ST_RUN) && i_ready;

    always_comb begin
        w_next_state = r_state;
        o_job_ready  = 1'b0;
        o_valid      = 1'b0;
        o_job_done   = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_job_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_job_valid) begin
                    w_next_state = (i_job_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_valid = 1'b1;
                // An abort coinciding with a handshake still lets that beat count.
                if (i_abort || (w_handshake && r_rem == cnt_width'(1))) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                o_job_done   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                o_busy       = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_blob  <= '0;
            r_nonce <= '0;
            r_rem   <= '0;
            r_sent  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_blob  <= i_job_blob;
                r_nonce <= i_job_start_nonce;
                r_rem   <= i_job_count;
                r_sent  <= '0;
            end else if (w_handshake) begin
                r_nonce <= r_nonce + 1'b1;
                r_rem   <= r_rem - 1'b1;
                r_sent  <= r_sent + 1'b1;
            end
        end
    end

    nonce_splice #(
        .input_width(input_width)
    ) u_splice (
        .i_blob (r_blob),
        .i_nonce(r_nonce),
        .o_blob (o_data)
    );

    assign o_nonce = r_nonce[nonce_width-1:0];
    assign o_sent  = r_sent;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed/randomized bench for nonce_dispatcher with a byte-level reference
// model of the spliced output and job bookkeeping.
module tb_nonce_dispatcher;

    localparam int W  = 2144;
    localparam int NW = 7;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_job_valid;
    logic          o_job_ready;
    logic [W-1:0]  i_job_blob;
    logic [31:0]   i_job_start_nonce;
    logic [CW-1:0] i_job_count;
    logic          i_abort;
    logic          o_valid;
    logic          i_ready;
    logic [NW-1:0] o_nonce;
    logic [W-1:0]  o_data;
    logic          o_busy;
    logic          o_job_done;
    logic [CW-1:0] o_sent;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nonce_dispatcher #(.nonce_width(NW), .input_width(W), .cnt_width(CW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_job_valid      (i_job_valid),
        .o_job_ready      (o_job_ready),
        .i_job_blob       (i_job_blob),
        .i_job_start_nonce(i_job_start_nonce),
        .i_job_count      (i_job_count),
        .i_abort          (i_abort),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_nonce          (o_nonce),
        .o_data           (o_data),
        .o_busy           (o_busy),
        .o_job_done       (o_job_done),
        .o_sent           (o_sent)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the blob byte by byte, substituting nonce bytes 39..42.
    function automatic logic [W-1:0] model_data(input logic [W-1:0] blob, input logic [31:0] n);
        logic [W-1:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < W / 8; k++) begin
            b = blob[W-1-8*k -: 8];
            if (k >= 39 && k <= 42) b = n[8*(k-39) +: 8];
            r[W-1-8*k -: 8] = b;
        end
        return r;
    endfunction

    function automatic logic [31:0] nonce_field(input logic [W-1:0] d);
        return {d[W-1-8*42 -: 8], d[W-1-8*41 -: 8], d[W-1-8*40 -: 8], d[W-1-8*39 -: 8]};
    endfunction

    function automatic logic [W-1:0] rand_blob();
        logic [W-1:0] b;
        for (int i = 0; i < W / 32; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Called at a negedge. mode: 0 ready always, 1 ready 1010..., 2 random.
    // abort_at: handshake number carrying the abort (0 = none).
    // stop_after: return mid-job once this many beats are done (-1 = never).
    task automatic run_job(input logic [W-1:0] blob, input logic [31:0] start,
                           input logic [31:0] count, input int mode,
                           input int abort_at, input int stop_after);
        int          hs;
        int          cyc;
        int          exp_sent;
        logic [31:0] n;
        logic        rdy;
        logic        ab;
        check("job_ready_idle", o_job_ready, 1);
        i_job_valid       = 1'b1;
        i_job_blob        = blob;
        i_job_start_nonce = start;
        i_job_count       = count;
        @(posedge clk);
        @(negedge clk);
        i_job_valid = 1'b0;
        if (count == 0) begin
            check("zero_valid", o_valid, 0);
            check("zero_done", o_job_done, 1);
            check("zero_busy", o_busy, 1);
            check("zero_sent", o_sent, 0);
            @(negedge clk);
            check("zero_done_end", o_job_done, 0);
            check("zero_ready_back", o_job_ready, 1);
            check("zero_valid_end", o_valid, 0);
            return;
        end
        hs  = 0;
        cyc = 0;
        ab  = 1'b0;
        while (!(hs == int'(count) || ab)) begin
            if (cyc > 4 * int'(count) + 20) begin
                n_tests++;
                n_fail++;
                $error("FAIL beat_timeout: observed %0d beats expected %0d", hs, count);
                return;
            end
            n = start + 32'(hs);
            check("beat_valid", o_valid, 1);
            check("beat_nonce", o_nonce, n[NW-1:0]);
            check("beat_sent", o_sent, hs);
            check("beat_splice", nonce_field(o_data), n);
            check("beat_data", (o_data === model_data(blob, n)), 1);
            check("beat_no_done", o_job_done, 0);
            if (stop_after == hs) return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ab      = rdy && (abort_at == hs + 1);
            i_ready = rdy;
            i_abort = ab;
            @(posedge clk);
            if (rdy) hs++;
            cyc++;
            @(negedge clk);
            i_ready = 1'b0;
            i_abort = 1'b0;
        end
        exp_sent = (abort_at > 0 && abort_at <= int'(count)) ? abort_at : int'(count);
        check("end_valid_low", o_valid, 0);
        check("end_done", o_job_done, 1);
        check("end_busy", o_busy, 1);
        check("end_sent", o_sent, exp_sent);
        @(negedge clk);
        check("end_done_one_cycle", o_job_done, 0);
        check("end_ready_back", o_job_ready, 1);
        check("end_busy_low", o_busy, 0);
        check("end_sent_held", o_sent, exp_sent);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] blob_inc;
        rstn              = 1'b0;
        i_job_valid       = 1'b0;
        i_job_blob        = '0;
        i_job_start_nonce = '0;
        i_job_count       = '0;
        i_abort           = 1'b0;
        i_ready           = 1'b0;
        for (int k = 0; k < W / 8; k++) blob_inc[W-1-8*k -: 8] = 8'(k);

        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_job_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_sent", o_sent, 0);
        check("rst_nonce", o_nonce, 0);
        check("rst_data_zero", (o_data === '0), 1);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_ready", o_job_ready, 1);

        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("idle_abort_ready", o_job_ready, 1);
        check("idle_abort_done", o_job_done, 0);

        run_job(blob_inc, 32'h0000_0010, 3, 0, 0, -1);
        run_job(blob_inc, 32'h0000_0010, 3, 1, 0, -1);
        run_job(rand_blob(), 32'hFFFF_FFFE, 4, 0, 0, -1);
        run_job(rand_blob(), $urandom(), 0, 0, 0, -1);
        run_job(rand_blob(), $urandom(), 100, 2, 5, -1);

        run_job(blob_inc, 32'h1234_5678, 10, 0, 0, 4);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_job_done, 0);
        check("arst_sent", o_sent, 0);
        check("arst_nonce", o_nonce, 0);
        check("arst_data_zero", (o_data === '0), 1);
        @(negedge clk);
        check("arst_no_done", o_job_done, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("arst_no_done_after", o_job_done, 0);
        run_job(rand_blob(), 32'hA5A5_0000, 5, 2, 0, -1);

        for (int j = 0; j < 4; j++) begin
            run_job(rand_blob(), $urandom(), 32'($urandom_range(1, 8)), 2, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
